// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control types and constants.
//   REG_W      : architectural register index width
//   REG_ZERO   : hard-wired zero register index, never a hazard source
//   hz_state_t : hazard controller operating state
package cpu_pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALTED
  } hz_state_t;

endpackage

// File: rtl/hz_load_use_cmp.sv
// Load-use hazard detector: flags when the load in EX writes a register that
// the instruction in ID reads. Register r0 never creates a dependency.
//   id_src_reg1/2, id_use_src1/2 : ID operand indices and read enables
//   ex_dst_reg, ex_use_dst_reg   : EX destination index and write enable
//   ex_mem_read                  : EX instruction is a load
//   hazard                       : combinational load-use indication
module hz_load_use_cmp
  import cpu_pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_src_reg1,
  input  logic [REG_W-1:0] id_src_reg2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] ex_dst_reg,
  input  logic             ex_use_dst_reg,
  input  logic             ex_mem_read,
  output logic             hazard
);

  logic ex_writes_real_reg;
  logic match1;
  logic match2;

  always_comb begin
    ex_writes_real_reg = ex_mem_read && ex_use_dst_reg && (ex_dst_reg != REG_ZERO);
    match1             = id_use_src1 && (id_src_reg1 == ex_dst_reg);
    match2             = id_use_src2 && (id_src_reg2 == ex_dst_reg);
    hazard             = ex_writes_real_reg && (match1 || match2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for the four pipeline registers and the PC.
// Handles load-use stalls, taken-branch flushes, memory-wait holds and the
// halt drain, and counts cycles in which the PC was held.
//   clk, rst            : clock, synchronous active-high reset
//   ID_* / EX_* / MEM_* : hazard sources from the pipeline stages
//   WB_hlt              : halt instruction has reached MEM/WB
//   *_stall / *_flush   : combinational pipeline-register controls
//   halted              : core fully halted (exit only through rst)
//   mem_timeout         : sticky, memory wait reached MEM_TIMEOUT cycles
//   stall_cycles        : saturating count of non-halted PC_stall cycles
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_src_reg1,
  input  logic [REG_W-1:0] ID_src_reg2,
  input  logic             ID_use_src1,
  input  logic             ID_use_src2,
  input  logic [REG_W-1:0] EX_dst_reg,
  input  logic             EX_use_dst_reg,
  input  logic             EX_mem_read,
  input  logic             EX_branch_taken,
  input  logic             MEM_mem_busy,
  input  logic             MEM_hlt,
  input  logic             WB_hlt,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_stall,
  output logic             MEM_WB_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              load_use;

  hz_load_use_cmp u_load_use (
    .id_src_reg1   (ID_src_reg1),
    .id_src_reg2   (ID_src_reg2),
    .id_use_src1   (ID_use_src1),
    .id_use_src2   (ID_use_src2),
    .ex_dst_reg    (EX_dst_reg),
    .ex_use_dst_reg(EX_use_dst_reg),
    .ex_mem_read   (EX_mem_read),
    .hazard        (load_use)
  );

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;
    PC_stall       = 1'b0;
    IF_ID_stall    = 1'b0;
    IF_ID_flush    = 1'b0;
    ID_EX_stall    = 1'b0;
    ID_EX_flush    = 1'b0;
    EX_MEM_stall   = 1'b0;
    EX_MEM_flush   = 1'b0;
    MEM_WB_stall   = 1'b0;
    MEM_WB_flush   = 1'b0;

    unique case (state_q)
      // MEM_WAIT behaves exactly like RUN once busy drops, so both share a branch.
      RUN, MEM_WAIT: begin
        if (MEM_mem_busy) begin
          PC_stall     = 1'b1;
          IF_ID_stall  = 1'b1;
          ID_EX_stall  = 1'b1;
          EX_MEM_stall = 1'b1;
          MEM_WB_flush = 1'b1;
          state_d      = MEM_WAIT;
        end else if (MEM_hlt) begin
          // Halt beats a branch in EX: the redirect is dropped and EX is flushed.
          PC_stall     = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          EX_MEM_flush = 1'b1;
          state_d      = DRAIN;
        end else begin
          state_d = RUN;
          if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
          end else if (load_use) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (MEM_mem_busy) begin
          PC_stall     = 1'b1;
          IF_ID_stall  = 1'b1;
          ID_EX_stall  = 1'b1;
          EX_MEM_stall = 1'b1;
          MEM_WB_flush = 1'b1;
        end else begin
          PC_stall     = 1'b1;
          IF_ID_flush  = 1'b1;
          ID_EX_flush  = 1'b1;
          EX_MEM_flush = 1'b1;
        end
        if (WB_hlt) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        PC_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_stall  = 1'b1;
        EX_MEM_stall = 1'b1;
        MEM_WB_stall = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (state_q != HALTED) begin
      if (MEM_mem_busy) begin
        if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // Flag as soon as the count reaches the limit so it is visible on the next busy cycle.
        if (wait_cnt_d == WAIT_MAX) begin
          mem_timeout_d = 1'b1;
        end
      end else begin
        wait_cnt_d = '0;
      end
      if (PC_stall && (stall_cycles_q != '1)) begin
        stall_cycles_d = stall_cycles_q + 1'b1;
      end
    end

    if (rst) begin
      PC_stall     = 1'b0;
      IF_ID_stall  = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_stall  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_stall = 1'b0;
      EX_MEM_flush = 1'b0;
      MEM_WB_stall = 1'b0;
      MEM_WB_flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign halted       = (state_q == HALTED);
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TMO     = 3;
  localparam int SC_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_src_reg1, ID_src_reg2, EX_dst_reg;
  logic ID_use_src1, ID_use_src2, EX_use_dst_reg, EX_mem_read;
  logic EX_branch_taken, MEM_mem_busy, MEM_hlt, WB_hlt;
  logic PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
  logic EX_MEM_stall, EX_MEM_flush, MEM_WB_stall, MEM_WB_flush;
  logic halted, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ID_src_reg1(ID_src_reg1), .ID_src_reg2(ID_src_reg2),
    .ID_use_src1(ID_use_src1), .ID_use_src2(ID_use_src2),
    .EX_dst_reg(EX_dst_reg), .EX_use_dst_reg(EX_use_dst_reg),
    .EX_mem_read(EX_mem_read), .EX_branch_taken(EX_branch_taken),
    .MEM_mem_busy(MEM_mem_busy), .MEM_hlt(MEM_hlt), .WB_hlt(WB_hlt),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_stall(EX_MEM_stall), .EX_MEM_flush(EX_MEM_flush),
    .MEM_WB_stall(MEM_WB_stall), .MEM_WB_flush(MEM_WB_flush),
    .halted(halted), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: whether the core is draining / halted, the run length of
  // consecutive busy cycles, the sticky timeout flag and the stall count.
  bit m_drain, m_halt, m_to;
  int m_busy_run, m_sc;
  bit e_pc, e_ifs, e_iff, e_exs, e_exf, e_ems, e_emf, e_mws, e_mwf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit load_use_now();
    if (!(EX_mem_read && EX_use_dst_reg && EX_dst_reg != 5'd0)) return 1'b0;
    return (ID_use_src1 && ID_src_reg1 == EX_dst_reg) ||
           (ID_use_src2 && ID_src_reg2 == EX_dst_reg);
  endfunction

  task automatic model_exp();
    {e_pc, e_ifs, e_iff, e_exs, e_exf, e_ems, e_emf, e_mws, e_mwf} = '0;
    if (rst) begin
      // everything low while reset is asserted
    end else if (m_halt) begin
      {e_pc, e_ifs, e_exs, e_ems, e_mws} = '1;
    end else if (MEM_mem_busy) begin
      {e_pc, e_ifs, e_exs, e_ems, e_mwf} = '1;
    end else if (m_drain || MEM_hlt) begin
      {e_pc, e_iff, e_exf, e_emf} = '1;
    end else if (EX_branch_taken) begin
      {e_iff, e_exf} = '1;
    end else if (load_use_now()) begin
      {e_pc, e_ifs, e_exf} = '1;
    end
  endtask

  task automatic model_clock();
    if (rst) begin
      m_drain = 0; m_halt = 0; m_to = 0; m_busy_run = 0; m_sc = 0;
    end else if (!m_halt) begin
      if (e_pc && m_sc < SC_MAX) m_sc++;
      if (MEM_mem_busy) begin
        m_busy_run++;
        if (m_busy_run >= TMO) m_to = 1;
      end else begin
        m_busy_run = 0;
      end
      if (m_drain) begin
        if (WB_hlt) begin m_halt = 1; m_drain = 0; end
      end else if (!MEM_mem_busy && MEM_hlt) begin
        m_drain = 1;
      end
    end
  endtask

  // Inputs are set after a negedge; compare, then advance one clock.
  task automatic step();
    #1;
    model_exp();
    chk("PC_stall", PC_stall, e_pc);
    chk("IF_ID_stall", IF_ID_stall, e_ifs);
    chk("IF_ID_flush", IF_ID_flush, e_iff);
    chk("ID_EX_stall", ID_EX_stall, e_exs);
    chk("ID_EX_flush", ID_EX_flush, e_exf);
    chk("EX_MEM_stall", EX_MEM_stall, e_ems);
    chk("EX_MEM_flush", EX_MEM_flush, e_emf);
    chk("MEM_WB_stall", MEM_WB_stall, e_mws);
    chk("MEM_WB_flush", MEM_WB_flush, e_mwf);
    chk("halted", halted, m_halt);
    chk("mem_timeout", mem_timeout, m_to);
    chk("stall_cycles", stall_cycles, m_sc);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0;
    ID_src_reg1 = 5'd1; ID_src_reg2 = 5'd2; EX_dst_reg = 5'd9;
    ID_use_src1 = 0; ID_use_src2 = 0; EX_use_dst_reg = 0; EX_mem_read = 0;
    EX_branch_taken = 0; MEM_mem_busy = 0; MEM_hlt = 0; WB_hlt = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    EX_mem_read = 1; EX_use_dst_reg = 1; EX_dst_reg = r;
    ID_use_src1 = 1; ID_src_reg1 = 5'd7;
    ID_use_src2 = 1; ID_src_reg2 = r;
  endtask

  initial begin
    m_drain = 0; m_halt = 0; m_to = 0; m_busy_run = 0; m_sc = 0;
    idle();
    @(negedge clk);

    // Reset state
    do_reset();
    #1;
    chk("rst_pc", PC_stall, 0); chk("rst_halted", halted, 0); chk("rst_sc", stall_cycles, 0);
    step();

    // Load r3 in EX, ID reads r3 through src2
    set_load_use(5'd3);
    #1; chk("lu_pc", PC_stall, 1); chk("lu_ifs", IF_ID_stall, 1); chk("lu_exf", ID_EX_flush, 1);
    step();
    idle();
    #1; chk("lu_sc", stall_cycles, 1); chk("lu_done_pc", PC_stall, 0);
    step();

    // Load to r0 never stalls
    set_load_use(5'd0); ID_src_reg1 = 5'd0;
    #1; chk("r0_pc", PC_stall, 0);
    step();
    // Branch suppresses load-use
    set_load_use(5'd4); EX_branch_taken = 1;
    #1; chk("br_pc", PC_stall, 0); chk("br_iff", IF_ID_flush, 1);
    chk("br_exf", ID_EX_flush, 1); chk("br_ifs", IF_ID_stall, 0);
    step();

    // Busy for 4 cycles
    idle(); MEM_mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk("busy_ems", EX_MEM_stall, 1); chk("busy_mwf", MEM_WB_flush, 1);
      step();
    end
    idle();
    #1; chk("busy_end_pc", PC_stall, 0); chk("busy_sc", stall_cycles, 5);
    step();

    // Timeout and counter saturation
    do_reset();
    MEM_mem_busy = 1;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (i <= 3) chk("tmo_early", mem_timeout, 0);
      if (i == 4) chk("tmo_rise", mem_timeout, 1);
      step();
    end
    idle();
    #1; chk("tmo_sticky", mem_timeout, 1); chk("sc_sat", stall_cycles, SC_MAX);
    step();

    // Halt with simultaneous branch, then WB_hlt
    do_reset();
    MEM_hlt = 1; EX_branch_taken = 1;
    #1; chk("hlt_pc", PC_stall, 1); chk("hlt_emf", EX_MEM_flush, 1); chk("hlt_iff", IF_ID_flush, 1);
    step();
    idle();
    #1; chk("drain_pc", PC_stall, 1); chk("drain_halted", halted, 0);
    step();
    WB_hlt = 1;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1; chk("halt_h", halted, 1); chk("halt_mws", MEM_WB_stall, 1); chk("halt_iff", IF_ID_flush, 0);
      step();
    end
    #1; chk("halt_sc", stall_cycles, 3);

    // Reset during drain
    do_reset();
    MEM_hlt = 1; step(); idle(); step();
    rst = 1; step(); rst = 0;
    #1; chk("rd_pc", PC_stall, 0); chk("rd_emf", EX_MEM_flush, 0);
    chk("rd_halted", halted, 0); chk("rd_sc", stall_cycles, 0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst             = ($urandom_range(0, 99) < (m_halt ? 20 : 1));
      ID_src_reg1     = 5'($urandom_range(0, 3));
      ID_src_reg2     = 5'($urandom_range(0, 3));
      EX_dst_reg      = 5'($urandom_range(0, 3));
      ID_use_src1     = 1'($urandom);
      ID_use_src2     = 1'($urandom);
      EX_use_dst_reg  = 1'($urandom);
      EX_mem_read     = 1'($urandom);
      EX_branch_taken = ($urandom_range(0, 99) < 20);
      MEM_mem_busy    = ($urandom_range(0, 99) < 30);
      MEM_hlt         = ($urandom_range(0, 99) < 4);
      WB_hlt          = ($urandom_range(0, 99) < 25);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
